branch_target_predictor: RTL

- Parametrised successor to the single 2-bit branch history register: a direct-mapped, tagged table of ENTRIES saturating counters of CTR_BITS each, with a branch target per entry.
- Fetch performs a combinational lookup each cycle. The mem stage writes back resolved branches.
- Adds tag matching, miss allocation, target storage, table clear and a mispredict statistics counter.

---
 rtl/branch_target_predictor_pkg.sv | 14 +
 rtl/branch_target_predictor_if.sv | 24 ++
 rtl/branch_target_predictor_sat_counter.sv | 20 ++
 rtl/branch_target_predictor.sv | 77 +++++++
 4 files changed

// File: rtl/branch_target_predictor_pkg.sv
// branch_target_predictor_pkg: shared constants and counter helper for the branch target predictor.
package branch_target_predictor_pkg;
    localparam int MAX_CTR_BITS = 4;
    localparam int CNT_W = 16;

    function automatic logic [MAX_CTR_BITS-1:0] sat_update(
        input logic [MAX_CTR_BITS-1:0] ctr,
        input logic                    taken,
        input logic [MAX_CTR_BITS-1:0] ctr_max
    );
        return taken ? ((ctr == ctr_max) ? ctr : ctr + 4'd1)
                     : ((ctr == '0) ? ctr : ctr - 4'd1);
    endfunction
endpackage

// File: rtl/branch_target_predictor_if.sv
// branch_target_predictor_if: fetch lookup and mem-stage update signals of the branch target predictor.
interface branch_target_predictor_if #(parameter int PC_W = 32);
    import branch_target_predictor_pkg::*;
    logic [PC_W-1:0]  lookup_pc;
    logic             predict_hit;
    logic             predict_taken;
    logic [PC_W-1:0]  predict_target;
    logic             update_en;
    logic [PC_W-1:0]  update_pc;
    logic             update_taken;
    logic [PC_W-1:0]  update_target;
    logic             update_mispredict;
    logic             clear;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output lookup_pc, update_en, update_pc, update_taken, update_target, update_mispredict, clear,
        input  predict_hit, predict_taken, predict_target, mispredict_count
    );
    modport slave (
        input  lookup_pc, update_en, update_pc, update_taken, update_target, update_mispredict, clear,
        output predict_hit, predict_taken, predict_target, mispredict_count
    );
endinterface

// File: rtl/branch_target_predictor_sat_counter.sv
// branch_target_predictor_sat_counter: next value of a saturating up/down counter with load.
module branch_target_predictor_sat_counter
    import branch_target_predictor_pkg::*;
#(
    parameter int W = 2
) (
    input  logic [W-1:0] val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] nxt_o
);
    localparam logic [MAX_CTR_BITS-1:0] MAX = MAX_CTR_BITS'((1 << W) - 1);

    always_comb
        nxt_o = load_i ? load_val_i
              : (inc_i || dec_i) ? W'(sat_update(MAX_CTR_BITS'(val_i), inc_i, MAX))
              : val_i;
endmodule

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped tagged table of saturating counters with branch targets.
// Lookup is combinational with no bypass of the same-cycle update.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int PC_W     = 32
) (
    input logic                       CLK,
    input logic                       nRST,
    branch_target_predictor_if.slave  bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [CTR_BITS-1:0] WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] WEAK_NT = WEAK_T - 1'b1;

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [CTR_BITS-1:0] ctr;
        logic [PC_W-1:0]     target;
    } bp_entry_t;

    localparam bp_entry_t RST_E = '{valid: 1'b0, tag: '0, ctr: WEAK_NT, target: '0};

    bp_entry_t           tbl_q [ENTRIES];
    bp_entry_t           l_e, u_e, upd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    l_idx, u_idx;
    logic [TAG_W-1:0]    l_tag, u_tag;
    logic                u_hit;
    logic [CTR_BITS-1:0] ctr_d;
    logic                unused_ok;

    assign l_idx = bp.lookup_pc[IDX_W+1:2];
    assign l_tag = bp.lookup_pc[PC_W-1:IDX_W+2];
    assign u_idx = bp.update_pc[IDX_W+1:2];
    assign u_tag = bp.update_pc[PC_W-1:IDX_W+2];
    assign unused_ok = ^{bp.lookup_pc[1:0], bp.update_pc[1:0]};
    assign l_e = tbl_q[l_idx];
    assign u_e = tbl_q[u_idx];
    assign u_hit = u_e.valid && u_e.tag == u_tag;

    assign bp.predict_hit      = l_e.valid && l_e.tag == l_tag;
    assign bp.predict_taken    = bp.predict_hit && l_e.ctr[CTR_BITS-1];
    assign bp.predict_target   = bp.predict_hit ? l_e.target : '0;
    assign bp.mispredict_count = cnt_q;

    branch_target_predictor_sat_counter #(.W(CTR_BITS)) u_ctr (
        .val_i      (u_e.ctr),
        .inc_i      (u_hit && bp.update_taken),
        .dec_i      (u_hit && !bp.update_taken),
        .load_i     (!u_hit),
        .load_val_i (bp.update_taken ? WEAK_T : WEAK_NT),
        .nxt_o      (ctr_d)
    );

    // a not-taken hit keeps its old target; a not-taken allocation clears it
    always_comb begin
        upd_d = '{valid: 1'b1, tag: u_tag, ctr: ctr_d,
                  target: bp.update_taken ? bp.update_target : (u_hit ? u_e.target : '0)};
        cnt_d = (bp.update_en && bp.update_mispredict && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= RST_E;
            cnt_q <= '0;
        end else begin
            if (bp.clear) for (int i = 0; i < ENTRIES; i++) tbl_q[i].valid <= 1'b0;
            else if (bp.update_en) tbl_q[u_idx] <= upd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule
